mem_load_store_unit: RTL and testbench

//  Multi-cycle MEM-stage load/store unit between the ALU-result/B registers and data memory.

---
 rtl/mips_ls_pkg.sv | 60 ++++++
 rtl/ls_load_align.sv | 33 +++
 rtl/mem_load_store_unit.sv | 131 +++++++++++++
 tb/tb_mem_load_store_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ls_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM encoding,
// byte-enable constants and small lane helpers.
package mips_ls_pkg;

  localparam logic [2:0] LS_LW  = 3'd0;
  localparam logic [2:0] LS_LH  = 3'd1;
  localparam logic [2:0] LS_LHU = 3'd2;
  localparam logic [2:0] LS_LB  = 3'd3;
  localparam logic [2:0] LS_LBU = 3'd4;
  localparam logic [2:0] LS_SW  = 3'd5;
  localparam logic [2:0] LS_SH  = 3'd6;
  localparam logic [2:0] LS_SB  = 3'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic logic is_store(input logic [2:0] op);
    return (op == LS_SW) || (op == LS_SH) || (op == LS_SB);
  endfunction

  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lo);
    logic ok;
    case (op)
      LS_LW, LS_SW:         ok = (lo == 2'b00);
      LS_LH, LS_LHU, LS_SH: ok = ~lo[0];
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Loads always fetch the whole word; the lane is picked after the ack.
  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] be;
    case (op)
      LS_SB:   be = BE_BYTE0 << lo;
      LS_SH:   be = lo[1] ? BE_HI_HALF : BE_LO_HALF;
      default: be = BE_ALL;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] data;
    case (op)
      LS_SB:   data = {4{wdata[7:0]}};
      LS_SH:   data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/ls_load_align.sv
// Combinational load aligner: picks the byte/half lane of the bus word and
// sign- or zero-extends it according to the load op.
module ls_load_align
  import mips_ls_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  op,
  output logic [31:0] load_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (byte_off)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      LS_LB:   load_word = {{24{byte_lane[7]}}, byte_lane};
      LS_LBU:  load_word = {24'd0, byte_lane};
      LS_LH:   load_word = {{16{half_lane[15]}}, half_lane};
      LS_LHU:  load_word = {16'd0, half_lane};
      default: load_word = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store unit: turns one controller request into a req/ack bus
// transaction, aligns load data into dr_out and reports misalign/timeout faults.
module mem_load_store_unit
  import mips_ls_pkg::*;
#(
  parameter int TIMEOUT = 16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] dr_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic       TIMEOUT_EN    = (TIMEOUT > 0);
  localparam logic [7:0] TIMEOUT_LIMIT = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_to_q, fault_to_d;
  logic [31:0] dr_q, dr_d;
  logic [31:0] load_word;

  ls_load_align u_align (
    .rdata     (mem_rdata),
    .byte_off  (addr_q[1:0]),
    .op        (op_q),
    .load_word (load_word)
  );

  // fault_to_q distinguishes a timeout fault (1) from a misalign fault (0).
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    fault_to_d = fault_to_q;
    dr_d       = dr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr;
          if (is_aligned(op, addr[1:0])) begin
            state_d = ST_ACCESS;
            cnt_d   = 8'd0;
            we_d    = is_store(op);
            be_d    = store_be(op, addr[1:0]);
            wdata_d = is_store(op) ? store_data(op, wdata) : 32'd0;
          end else begin
            state_d    = ST_FAULT;
            fault_to_d = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!is_store(op_q)) begin
            dr_d = load_word;
          end
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LIMIT)) begin
          state_d    = ST_FAULT;
          fault_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= LS_LW;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= BE_NONE;
      we_q       <= 1'b0;
      cnt_q      <= 8'd0;
      fault_to_q <= 1'b0;
      dr_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      fault_to_q <= fault_to_d;
      dr_q       <= dr_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign misalign  = (state_q == ST_FAULT) && !fault_to_q;
  assign bus_err   = (state_q == ST_FAULT) && fault_to_q;
  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign dr_out    = dr_q;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Directed self-checking bench for mem_load_store_unit with hand-computed
// expected values; inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic        bus_err;
  logic [31:0] dr_out;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int vec_count;
  int miss_count;

  mem_load_store_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .dr_out    (dr_out),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises start for cycle 0 and returns positioned in cycle 1.
  task automatic applyStimulus(input logic [2:0] s_op, input logic [31:0] s_addr, input logic [31:0] s_wdata);
    start = 1'b1;
    op    = s_op;
    addr  = s_addr;
    wdata = s_wdata;
    tick();
    start = 1'b0;
  endtask

  // Load acked in cycle 1; checks done and dr_out in cycle 2.
  task automatic quickLoad(input string tag, input logic [2:0] l_op, input logic [31:0] l_addr,
                           input logic [31:0] rdata, input logic [31:0] exp_dr);
    applyStimulus(l_op, l_addr, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " dr_out"}, dr_out, exp_dr);
    tick();
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    op         = 3'd0;
    addr       = 32'd0;
    wdata      = 32'd0;
    mem_rdata  = 32'd0;
    mem_ack    = 1'b0;

    #12;
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst flags", {29'd0, done, misalign, bus_err}, 32'd0);
    checkOutput("rst mem_req/we", {30'd0, mem_req, mem_we}, 32'd0);
    checkOutput("rst mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst dr_out", dr_out, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // LW, ack in cycle 1, done in cycle 2
    applyStimulus(3'd0, 32'h0000_0100, 32'd0);
    checkOutput("lw c1 mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("lw c1 busy", {31'd0, busy}, 32'd1);
    checkOutput("lw c1 mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("lw c1 mem_be", {28'd0, mem_be}, 32'h0000_000F);
    checkOutput("lw c1 mem_addr", mem_addr, 32'h0000_0100);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    checkOutput("lw c2 done", {31'd0, done}, 32'd1);
    checkOutput("lw c2 mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("lw c2 dr_out", dr_out, 32'hDEAD_BEEF);
    tick();
    checkOutput("lw c3 busy/done", {30'd0, busy, done}, 32'd0);

    // LB with ack delayed to cycle 3: request must hold, no early done
    applyStimulus(3'd3, 32'h0000_0103, 32'd0);
    tick();
    checkOutput("lb c2 mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("lb c2 done", {31'd0, done}, 32'd0);
    checkOutput("lb c2 mem_addr", mem_addr, 32'h0000_0100);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h8011_2233;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    checkOutput("lb c4 done", {31'd0, done}, 32'd1);
    checkOutput("lb c4 dr_out", dr_out, 32'hFFFF_FF80);
    tick();

    quickLoad("lbu", 3'd4, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080);
    quickLoad("lh",  3'd1, 32'h0000_0102, 32'h8011_2233, 32'hFFFF_8011);
    quickLoad("lhu", 3'd2, 32'h0000_0102, 32'h8011_2233, 32'h0000_8011);
    quickLoad("lb0", 3'd3, 32'h0000_0100, 32'h8011_2233, 32'h0000_0033);

    // SB: lane replication and single-byte enable; dr_out must hold
    applyStimulus(3'd7, 32'h0000_0201, 32'h0000_00A5);
    checkOutput("sb mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("sb mem_be", {28'd0, mem_be}, 32'h0000_0002);
    checkOutput("sb mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    checkOutput("sb mem_addr", mem_addr, 32'h0000_0200);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    checkOutput("sb done", {31'd0, done}, 32'd1);
    checkOutput("sb dr_out hold", dr_out, 32'h0000_0033);
    tick();

    // SH upper half
    applyStimulus(3'd6, 32'h0000_0202, 32'hFFFF_1234);
    checkOutput("sh mem_be", {28'd0, mem_be}, 32'h0000_000C);
    checkOutput("sh mem_wdata", mem_wdata, 32'h1234_1234);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // SW misaligned: fault pulse, no bus access
    applyStimulus(3'd5, 32'h0000_0102, 32'h1111_1111);
    checkOutput("sw-mis misalign", {31'd0, misalign}, 32'd1);
    checkOutput("sw-mis mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("sw-mis done/bus_err", {30'd0, done, bus_err}, 32'd0);
    checkOutput("sw-mis busy", {31'd0, busy}, 32'd1);
    checkOutput("sw-mis dr_out", dr_out, 32'h0000_0033);
    tick();
    checkOutput("sw-mis c2 busy/misalign", {30'd0, busy, misalign}, 32'd0);

    // LH at odd address is misaligned
    applyStimulus(3'd1, 32'h0000_0101, 32'd0);
    checkOutput("lh-mis misalign", {31'd0, misalign}, 32'd1);
    checkOutput("lh-mis mem_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Timeout: no ack ever, bus_err in cycle 17
    applyStimulus(3'd0, 32'h0000_0300, 32'd0);
    for (int c = 1; c < 16; c++) tick();
    checkOutput("to c16 mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("to c16 bus_err", {31'd0, bus_err}, 32'd0);
    tick();
    checkOutput("to c17 bus_err", {31'd0, bus_err}, 32'd1);
    checkOutput("to c17 mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("to c17 done/misalign", {30'd0, done, misalign}, 32'd0);
    tick();
    checkOutput("to c18 busy", {31'd0, busy}, 32'd0);

    // Ack in the limit cycle beats the timeout
    applyStimulus(3'd0, 32'h0000_0304, 32'd0);
    for (int c = 1; c < 16; c++) tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    checkOutput("to-edge done", {31'd0, done}, 32'd1);
    checkOutput("to-edge bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("to-edge dr_out", dr_out, 32'hCAFE_F00D);
    tick();

    // Second start while busy is ignored
    applyStimulus(3'd0, 32'h0000_0400, 32'd0);
    start = 1'b1;
    op    = 3'd5;
    addr  = 32'h0000_0500;
    wdata = 32'h5555_5555;
    tick();
    start = 1'b0;
    checkOutput("busy-start mem_addr", mem_addr, 32'h0000_0400);
    checkOutput("busy-start mem_we", {31'd0, mem_we}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    checkOutput("busy-start done", {31'd0, done}, 32'd1);
    checkOutput("busy-start dr_out", dr_out, 32'h1122_3344);
    start = 1'b1;
    op    = 3'd0;
    addr  = 32'h0000_0600;
    tick();
    start = 1'b0;
    checkOutput("done-start busy", {31'd0, busy}, 32'd0);
    checkOutput("done-start mem_req", {31'd0, mem_req}, 32'd0);

    // Async reset mid-transaction drops mem_req immediately
    applyStimulus(3'd0, 32'h0000_0700, 32'd0);
    checkOutput("rst-mid pre mem_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst-mid mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst-mid busy", {31'd0, busy}, 32'd0);
    checkOutput("rst-mid dr_out", dr_out, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("rst-mid after busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
